// File: rtl/adder_result_checker.sv
// Result monitor for an adder: aligns captured operands to the adder output by a
// fixed latency, compares against the zero-extended sum, and logs the first failure.
module adder_result_checker #(
  parameter int unsigned  WIDTH_A      = 8,
  parameter int unsigned  WIDTH_B      = 8,
  parameter int unsigned  LATENCY      = 0,
  parameter int unsigned  CNT_WIDTH    = 16,
  parameter bit           STOP_ON_FAIL = 1'b0,
  localparam int unsigned RW           = ((WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B) + 1
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [WIDTH_A-1:0]   a,
  input  logic [WIDTH_B-1:0]   b,
  input  logic [RW-1:0]        result,
  output logic [CNT_WIDTH-1:0] check_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic                 error,
  output logic                 halted,
  output logic [WIDTH_A-1:0]   fail_a,
  output logic [WIDTH_B-1:0]   fail_b,
  output logic [RW-1:0]        fail_result,
  output logic [RW-1:0]        fail_expected
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   check_cnt_q, check_cnt_d;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic                   error_q, error_d;
  logic                   halted_q, halted_d;
  logic [WIDTH_A-1:0]     fail_a_q, fail_a_d;
  logic [WIDTH_B-1:0]     fail_b_q, fail_b_d;
  logic [RW-1:0]          fail_res_q, fail_res_d;
  logic [RW-1:0]          fail_exp_q, fail_exp_d;

  logic                   al_valid;
  logic [WIDTH_A-1:0]     al_a;
  logic [WIDTH_B-1:0]     al_b;
  logic [RW-1:0]          expected;
  logic                   flush;
  logic                   do_cmp;
  logic                   mismatch;

  // Leaving CHECK or clearing discards everything still in flight.
  assign flush = clear | ((state_q == ST_CHECK) & ~en);

  // Operand alignment: direct path at zero latency, otherwise a shift register.
  if (LATENCY == 0) begin : g_direct
    assign al_valid = in_valid;
    assign al_a     = a;
    assign al_b     = b;
  end else begin : g_delay
    logic [LATENCY-1:0] dv_q;
    logic [WIDTH_A-1:0] da_q [LATENCY];
    logic [WIDTH_B-1:0] db_q [LATENCY];

    always_ff @(posedge clk) begin
      if (RST || flush) begin
        dv_q <= '0;
      end else begin
        dv_q[0] <= in_valid & en;
        for (int i = 1; i < int'(LATENCY); i++) begin
          dv_q[i] <= dv_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      da_q[0] <= a;
      db_q[0] <= b;
      for (int i = 1; i < int'(LATENCY); i++) begin
        da_q[i] <= da_q[i-1];
        db_q[i] <= db_q[i-1];
      end
    end

    assign al_valid = dv_q[LATENCY-1];
    assign al_a     = da_q[LATENCY-1];
    assign al_b     = db_q[LATENCY-1];
  end

  assign expected = RW'(al_a) + RW'(al_b);
  assign do_cmp   = (state_q == ST_CHECK) & en & ~clear & al_valid;
  assign mismatch = do_cmp & (result != expected);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (STOP_ON_FAIL && mismatch) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = en ? ST_CHECK : ST_IDLE;
  end

  // Counters and first-failure capture; clear beats a same-cycle compare.
  always_comb begin
    check_cnt_d = check_cnt_q;
    err_cnt_d   = err_cnt_q;
    error_d     = error_q;
    fail_a_d    = fail_a_q;
    fail_b_d    = fail_b_q;
    fail_res_d  = fail_res_q;
    fail_exp_d  = fail_exp_q;
    halted_d    = (state_d == ST_HALT);
    if (clear) begin
      check_cnt_d = '0;
      err_cnt_d   = '0;
      error_d     = 1'b0;
      fail_a_d    = '0;
      fail_b_d    = '0;
      fail_res_d  = '0;
      fail_exp_d  = '0;
    end else if (do_cmp) begin
      if (check_cnt_q != CNT_MAX) check_cnt_d = check_cnt_q + CNT_WIDTH'(1);
      if (mismatch) begin
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        error_d = 1'b1;
        if (!error_q) begin
          fail_a_d   = al_a;
          fail_b_d   = al_b;
          fail_res_d = result;
          fail_exp_d = expected;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      check_cnt_q <= '0;
      err_cnt_q   <= '0;
      error_q     <= 1'b0;
      halted_q    <= 1'b0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_res_q  <= '0;
      fail_exp_q  <= '0;
    end else begin
      state_q     <= state_d;
      check_cnt_q <= check_cnt_d;
      err_cnt_q   <= err_cnt_d;
      error_q     <= error_d;
      halted_q    <= halted_d;
      fail_a_q    <= fail_a_d;
      fail_b_q    <= fail_b_d;
      fail_res_q  <= fail_res_d;
      fail_exp_q  <= fail_exp_d;
    end
  end

  assign check_count   = check_cnt_q;
  assign error_count   = err_cnt_q;
  assign error         = error_q;
  assign halted        = halted_q;
  assign fail_a        = fail_a_q;
  assign fail_b        = fail_b_q;
  assign fail_result   = fail_res_q;
  assign fail_expected = fail_exp_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: four configurations share one stimulus stream and
// are checked every cycle against a transaction-level model plus literal expectations.
module tb_adder_result_checker;

  logic        clk = 1'b0;
  logic        rst, en, clr, vld;
  logic [31:0] sa, sb, sr;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance parameters: u0 sat counter, u1 wide/latency 2, u2 stop-on-fail, u3 latency 3.
  localparam int P_WA  [4] = '{8, 9, 8, 8};
  localparam int P_WB  [4] = '{8, 16, 8, 8};
  localparam int P_L   [4] = '{0, 2, 0, 3};
  localparam int P_CW  [4] = '{4, 16, 16, 16};
  localparam int P_SOF [4] = '{0, 0, 1, 0};

  logic [3:0]  cc0, ec0;   logic e0, h0; logic [7:0] fa0, fb0; logic [8:0]  fr0, fe0;
  logic [15:0] cc1, ec1;   logic e1, h1; logic [8:0] fa1; logic [15:0] fb1; logic [16:0] fr1, fe1;
  logic [15:0] cc2, ec2;   logic e2, h2; logic [7:0] fa2, fb2; logic [8:0]  fr2, fe2;
  logic [15:0] cc3, ec3;   logic e3, h3; logic [7:0] fa3, fb3; logic [8:0]  fr3, fe3;

  adder_result_checker #(.WIDTH_A(8), .WIDTH_B(8), .LATENCY(0), .CNT_WIDTH(4), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .RST(rst), .en(en), .clear(clr), .in_valid(vld), .a(sa[7:0]), .b(sb[7:0]),
    .result(sr[8:0]), .check_count(cc0), .error_count(ec0), .error(e0), .halted(h0),
    .fail_a(fa0), .fail_b(fb0), .fail_result(fr0), .fail_expected(fe0));
  adder_result_checker #(.WIDTH_A(9), .WIDTH_B(16), .LATENCY(2), .CNT_WIDTH(16), .STOP_ON_FAIL(1'b0)) u1 (
    .clk(clk), .RST(rst), .en(en), .clear(clr), .in_valid(vld), .a(sa[8:0]), .b(sb[15:0]),
    .result(sr[16:0]), .check_count(cc1), .error_count(ec1), .error(e1), .halted(h1),
    .fail_a(fa1), .fail_b(fb1), .fail_result(fr1), .fail_expected(fe1));
  adder_result_checker #(.WIDTH_A(8), .WIDTH_B(8), .LATENCY(0), .CNT_WIDTH(16), .STOP_ON_FAIL(1'b1)) u2 (
    .clk(clk), .RST(rst), .en(en), .clear(clr), .in_valid(vld), .a(sa[7:0]), .b(sb[7:0]),
    .result(sr[8:0]), .check_count(cc2), .error_count(ec2), .error(e2), .halted(h2),
    .fail_a(fa2), .fail_b(fb2), .fail_result(fr2), .fail_expected(fe2));
  adder_result_checker #(.WIDTH_A(8), .WIDTH_B(8), .LATENCY(3), .CNT_WIDTH(16), .STOP_ON_FAIL(1'b0)) u3 (
    .clk(clk), .RST(rst), .en(en), .clear(clr), .in_valid(vld), .a(sa[7:0]), .b(sb[7:0]),
    .result(sr[8:0]), .check_count(cc3), .error_count(ec3), .error(e3), .halted(h3),
    .fail_a(fa3), .fail_b(fb3), .fail_result(fr3), .fail_expected(fe3));

  // ---------------- transaction-level model ----------------
  localparam int M_IDLE = 0, M_CHECK = 1, M_HALT = 2;

  typedef struct {
    int          k;
    int          due;
    logic [63:0] a;
    logic [63:0] b;
  } tx_t;

  tx_t         pend[$];
  int          m_cyc  = 0;
  bit          m_init = 0;
  int          m_mode [4];
  logic [63:0] m_cc [4], m_ec [4], m_fa [4], m_fb [4], m_fr [4], m_fe [4];
  bit          m_err [4];

  function automatic logic [63:0] msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic int rw_of(input int k);
    return ((P_WA[k] > P_WB[k]) ? P_WA[k] : P_WB[k]) + 1;
  endfunction

  task automatic purge(input int k, input bit all);
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].k == k && (all || pend[i].due <= m_cyc)) pend.delete(i);
  endtask

  task automatic model_step(input int k);
    logic [63:0] ma, mb, ta, tb, ex, rr;
    bit found, cmp, mis, flush;
    ma = 64'(sa) & msk(P_WA[k]);
    mb = 64'(sb) & msk(P_WB[k]);
    rr = 64'(sr) & msk(rw_of(k));
    if (rst) begin
      m_cc[k] = 0; m_ec[k] = 0; m_err[k] = 0; m_mode[k] = M_IDLE;
      m_fa[k] = 0; m_fb[k] = 0; m_fr[k] = 0; m_fe[k] = 0;
      purge(k, 1'b1);
      return;
    end
    found = 0; ta = 0; tb = 0;
    if (P_L[k] == 0) begin
      found = vld; ta = ma; tb = mb;
    end else begin
      foreach (pend[i])
        if (pend[i].k == k && pend[i].due == m_cyc) begin
          found = 1; ta = pend[i].a; tb = pend[i].b;
        end
    end
    cmp   = (m_mode[k] == M_CHECK) && en && !clr && found;
    ex    = ta + tb;
    mis   = cmp && (rr != ex);
    flush = clr || (m_mode[k] == M_CHECK && !en);
    if (clr) begin
      m_cc[k] = 0; m_ec[k] = 0; m_err[k] = 0;
      m_fa[k] = 0; m_fb[k] = 0; m_fr[k] = 0; m_fe[k] = 0;
      m_mode[k] = en ? M_CHECK : M_IDLE;
    end else begin
      if (cmp) begin
        if (m_cc[k] < msk(P_CW[k])) m_cc[k] = m_cc[k] + 1;
        if (mis) begin
          if (m_ec[k] < msk(P_CW[k])) m_ec[k] = m_ec[k] + 1;
          if (!m_err[k]) begin
            m_fa[k] = ta; m_fb[k] = tb; m_fr[k] = rr; m_fe[k] = ex;
          end
          m_err[k] = 1;
        end
      end
      if (m_mode[k] == M_IDLE && en) m_mode[k] = M_CHECK;
      else if (m_mode[k] == M_CHECK && !en) m_mode[k] = M_IDLE;
      else if (m_mode[k] == M_CHECK && mis && P_SOF[k] != 0) m_mode[k] = M_HALT;
    end
    purge(k, flush);
    if (!flush && P_L[k] > 0 && vld && en) pend.push_back('{k, m_cyc + P_L[k], ma, mb});
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) model_step(k);
    m_cyc++;
    if (rst) m_init = 1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_inst(input int k, input logic [63:0] cc, ec, e, h, fa, fb, fr, fe);
    chk($sformatf("u%0d.check_count", k), cc, m_cc[k]);
    chk($sformatf("u%0d.error_count", k), ec, m_ec[k]);
    chk($sformatf("u%0d.error", k), e, 64'(m_err[k]));
    chk($sformatf("u%0d.halted", k), h, 64'(m_mode[k] == M_HALT));
    chk($sformatf("u%0d.fail_a", k), fa, m_fa[k]);
    chk($sformatf("u%0d.fail_b", k), fb, m_fb[k]);
    chk($sformatf("u%0d.fail_result", k), fr, m_fr[k]);
    chk($sformatf("u%0d.fail_expected", k), fe, m_fe[k]);
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chk_inst(0, 64'(cc0), 64'(ec0), 64'(e0), 64'(h0), 64'(fa0), 64'(fb0), 64'(fr0), 64'(fe0));
      chk_inst(1, 64'(cc1), 64'(ec1), 64'(e1), 64'(h1), 64'(fa1), 64'(fb1), 64'(fr1), 64'(fe1));
      chk_inst(2, 64'(cc2), 64'(ec2), 64'(e2), 64'(h2), 64'(fa2), 64'(fb2), 64'(fr2), 64'(fe2));
      chk_inst(3, 64'(cc3), 64'(ec3), 64'(e3), 64'(h3), 64'(fa3), 64'(fb3), 64'(fr3), 64'(fe3));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic e, input logic c, input logic v,
                       input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tr);
    @(negedge clk);
    rst = r; en = e; clr = c; vld = v; sa = ta; sb = tb; sr = tr;
  endtask

  task automatic idle(input logic e);
    drive(1'b0, e, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    idle(1'b1);
    idle(1'b1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; vld = 1'b0; sa = '0; sb = '0; sr = '0;

    // Reset state
    do_reset();
    chk("reset.cc0", 64'(cc0), 64'd0);
    chk("reset.err0", 64'(e0), 64'd0);
    chk("reset.halt2", 64'(h2), 64'd0);

    // Zero-latency match, mismatch, second mismatch
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd200, 32'd234, 32'd434);
    idle(1'b1);
    chk("l0.match.cc", 64'(cc0), 64'd1);
    chk("l0.match.ec", 64'(ec0), 64'd0);
    chk("l0.match.err", 64'(e0), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd200, 32'd234, 32'd433);
    idle(1'b1);
    chk("l0.mis.ec", 64'(ec0), 64'd1);
    chk("l0.mis.err", 64'(e0), 64'd1);
    chk("l0.mis.fa", 64'(fa0), 64'd200);
    chk("l0.mis.fb", 64'(fb0), 64'd234);
    chk("l0.mis.fr", 64'(fr0), 64'd433);
    chk("l0.mis.fe", 64'(fe0), 64'd434);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd1, 32'd0);
    idle(1'b1);
    chk("l0.mis2.ec", 64'(ec0), 64'd2);
    chk("l0.mis2.fr", 64'(fr0), 64'd433);
    chk("l0.mis2.cc", 64'(cc0), 64'd3);

    // Latency 2, mixed widths
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd300, 32'd425, 32'd7);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd99);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd725);
    idle(1'b1);
    chk("l2.match.cc", 64'(cc1), 64'd1);
    chk("l2.match.err", 64'(e1), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd300, 32'd425, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd725);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1);
    idle(1'b1);
    chk("l2.early.err", 64'(e1), 64'd1);
    chk("l2.early.fe", 64'(fe1), 64'd725);
    chk("l2.early.fr", 64'(fr1), 64'd1);
    chk("l2.early.cc", 64'(cc1), 64'd2);

    // Counter saturation at 15 with a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0);
    idle(1'b1);
    chk("sat.ec", 64'(ec0), 64'd15);
    chk("sat.cc", 64'(cc0), 64'd15);
    chk("sat.fa", 64'(fa0), 64'd1);

    // Stop on fail, freeze, clear and resume
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd1, 32'd2);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd10, 32'd20, 32'd31);
    idle(1'b1);
    chk("sof.halted", 64'(h2), 64'd1);
    chk("sof.err", 64'(e2), 64'd1);
    chk("sof.cc", 64'(cc2), 64'd5);
    chk("sof.fe", 64'(fe2), 64'd30);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd2, 32'd3, 32'd5);
    idle(1'b1);
    chk("sof.frozen.cc", 64'(cc2), 64'd5);
    chk("sof.frozen.halted", 64'(h2), 64'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    idle(1'b0);
    chk("clr.cc", 64'(cc2), 64'd0);
    chk("clr.ec", 64'(ec2), 64'd0);
    chk("clr.err", 64'(e2), 64'd0);
    chk("clr.halted", 64'(h2), 64'd0);
    chk("clr.fe", 64'(fe2), 64'd0);
    idle(1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd4, 32'd7);
    idle(1'b1);
    chk("resume.cc", 64'(cc2), 64'd1);
    chk("resume.err", 64'(e2), 64'd0);

    // Latency 3: reset kills in-flight transactions
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd6, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd7, 32'd8, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    idle(1'b1);
    chk("l3.rst.cc", 64'(cc3), 64'd0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("l3.rst.late.cc", 64'(cc3), 64'd0);
    chk("l3.rst.late.err", 64'(e3), 64'd0);

    // Latency 3: dropping en flushes in-flight transactions
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd6, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd7, 32'd8, 32'd0);
    idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("l3.en.cc", 64'(cc3), 64'd0);
    chk("l3.en.ec", 64'(ec3), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0);
    idle(1'b1);
    idle(1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd3);
    idle(1'b1);
    chk("l3.ok.cc", 64'(cc3), 64'd1);
    chk("l3.ok.err", 64'(e3), 64'd0);

    idle(1'b0);
    idle(1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
